// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the two-port main_mem line arbiter
package mem_arb_pkg;
  localparam int ARB_LINE_ADDR_LEN_DEF = 3;
  localparam int ARB_LINE_BITS_DEF = 32 << ARB_LINE_ADDR_LEN_DEF;
  typedef logic [ARB_LINE_BITS_DEF-1:0] line_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic {ARB_PORT0, ARB_PORT1} arb_port_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: winner select between two line requesters
// MEM_ARB_FIXED_PRIO_EN: port1 always wins contention, otherwise round-robin on rr_last
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_rr_last,
  output logic o_pick
);
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign o_pick = i_req1;
`else
  assign o_pick = i_req1 & (!i_req0 | (arb_port_t'(i_rr_last) == ARB_PORT0));
`endif
endmodule

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: serialises I-side (port0) and D-side (port1) line transactions onto main_mem
// Contention policy selected by MEM_ARB_FIXED_PRIO_EN (see mem_arb_pick)
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int MEM_ADDR_LEN  = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [MEM_ADDR_LEN-1:0]         m0_addr,
  input  logic                            m0_rd_req,
  input  logic                            m0_wr_req,
  input  logic [(32<<LINE_ADDR_LEN)-1:0]  m0_wr_line,
  output logic [(32<<LINE_ADDR_LEN)-1:0]  m0_rd_line,
  output logic                            m0_gnt,
  input  logic [MEM_ADDR_LEN-1:0]         m1_addr,
  input  logic                            m1_rd_req,
  input  logic                            m1_wr_req,
  input  logic [(32<<LINE_ADDR_LEN)-1:0]  m1_wr_line,
  output logic [(32<<LINE_ADDR_LEN)-1:0]  m1_rd_line,
  output logic                            m1_gnt,
  output logic [MEM_ADDR_LEN-1:0]         mem_addr,
  output logic                            mem_rd_req,
  output logic                            mem_wr_req,
  output logic [(32<<LINE_ADDR_LEN)-1:0]  mem_wr_line,
  input  logic [(32<<LINE_ADDR_LEN)-1:0]  mem_rd_line,
  input  logic                            mem_gnt
);
  localparam int LW = 32 << LINE_ADDR_LEN;
  arb_state_t              r_state;
  arb_port_t               r_rr_last;
  arb_port_t               r_owner;
  logic [MEM_ADDR_LEN-1:0] r_mem_addr;
  logic                    r_mem_rd;
  logic                    r_mem_wr;
  logic [LW-1:0]           r_mem_wr_line;
  logic [LW-1:0]           r_m0_rd_line;
  logic [LW-1:0]           r_m1_rd_line;
  logic                    r_m0_gnt;
  logic                    r_m1_gnt;
  logic                    w_req0;
  logic                    w_req1;
  logic                    w_pick;
  logic                    w_wr;
  assign w_req0 = m0_rd_req | m0_wr_req;
  assign w_req1 = m1_rd_req | m1_wr_req;
  // a port raising both rd and wr is served as a write
  assign w_wr = w_pick ? m1_wr_req : m0_wr_req;
  mem_arb_pick u_pick (
    .i_req0   (w_req0),
    .i_req1   (w_req1),
    .i_rr_last(r_rr_last),
    .o_pick   (w_pick)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ARB_IDLE;
      r_rr_last     <= ARB_PORT1;
      r_owner       <= ARB_PORT0;
      r_mem_addr    <= '0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_wr_line <= '0;
      r_m0_rd_line  <= '0;
      r_m1_rd_line  <= '0;
      r_m0_gnt      <= 1'b0;
      r_m1_gnt      <= 1'b0;
    end else begin
      r_m0_gnt <= 1'b0;
      r_m1_gnt <= 1'b0;
      case (r_state)
        ARB_IDLE: if (w_req0 | w_req1) begin
          r_state       <= ARB_BUSY;
          r_owner       <= arb_port_t'(w_pick);
          r_rr_last     <= arb_port_t'(w_pick);
          r_mem_addr    <= w_pick ? m1_addr : m0_addr;
          r_mem_wr_line <= w_pick ? m1_wr_line : m0_wr_line;
          r_mem_wr      <= w_wr;
          r_mem_rd      <= !w_wr;
        end
        ARB_BUSY: if (mem_gnt) begin
          // r_mem_rd still encodes the op until it is dropped here
          r_state  <= ARB_RESP;
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
          r_m0_gnt <= r_owner == ARB_PORT0;
          r_m1_gnt <= r_owner == ARB_PORT1;
          if (r_mem_rd && r_owner == ARB_PORT0) r_m0_rd_line <= mem_rd_line;
          if (r_mem_rd && r_owner == ARB_PORT1) r_m1_rd_line <= mem_rd_line;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end
  assign mem_addr    = r_mem_addr;
  assign mem_rd_req  = r_mem_rd;
  assign mem_wr_req  = r_mem_wr;
  assign mem_wr_line = r_mem_wr_line;
  assign m0_rd_line  = r_m0_rd_line;
  assign m1_rd_line  = r_m1_rd_line;
  assign m0_gnt      = r_m0_gnt;
  assign m1_gnt      = r_m1_gnt;
endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter: randomized scoreboard bench with a main_mem model of random 1..8 cycle grant delay
module tb_mem_line_arbiter;
  import mem_arb_pkg::*;
  logic clk, rst;
  logic [6:0] m0_addr, m1_addr, mem_addr;
  logic m0_rd_req, m0_wr_req, m1_rd_req, m1_wr_req, m0_gnt, m1_gnt;
  logic mem_rd_req, mem_wr_req, mem_gnt;
  line_t m0_wr_line, m1_wr_line, m0_rd_line, m1_rd_line, mem_wr_line, mem_rd_line;
  line_t mm [128];
  line_t ref_mem [128];
  line_t last_rd [2];
  line_t q0 [$];
  line_t q1 [$];
  int gnt_log [$];
  int n_checks = 0, n_fail = 0, mem_delay = 0;
  bit mon_en = 0, gnt_due = 0;

  mem_line_arbiter #(.LINE_ADDR_LEN(3), .MEM_ADDR_LEN(7)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_rd_req(m0_rd_req), .m0_wr_req(m0_wr_req),
    .m0_wr_line(m0_wr_line), .m0_rd_line(m0_rd_line), .m0_gnt(m0_gnt),
    .m1_addr(m1_addr), .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req),
    .m1_wr_line(m1_wr_line), .m1_rd_line(m1_rd_line), .m1_gnt(m1_gnt),
    .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic line_t init_line(input int a);
    line_t r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = {8'hC0, 1'b0, 7'(a), 8'(w), 8'h5A};
    return r;
  endfunction

  function automatic line_t rnd_line();
    line_t r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input int p, input bit rd, input bit wr, input logic [6:0] a, input line_t l);
    if (p == 0) begin m0_rd_req = rd; m0_wr_req = wr; m0_addr = a; m0_wr_line = l; end
    else begin m1_rd_req = rd; m1_wr_req = wr; m1_addr = a; m1_wr_line = l; end
  endtask

  // one requester transaction; the expected read-back comes from the reference memory
  task automatic do_txn(input int p, input bit rd, input bit wr, input logic [6:0] a, input line_t l, input bit lone);
    line_t e;
    bit done = 0;
    if (wr) begin ref_mem[a] = l; e = last_rd[p]; end
    else begin e = ref_mem[a]; last_rd[p] = e; end
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    drive(p, rd, wr, a, l);
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if ((p == 0 ? m0_gnt : m1_gnt) === 1'b1) done = 1;
      else if (lone && t == 0) begin
        chk("mem_op", {mem_rd_req, mem_wr_req}, wr ? 2'b01 : 2'b10);
        chk("mem_addr", mem_addr, a);
        if (wr) chk("mem_wr_line", mem_wr_line, l);
        drive(p, rd, wr, a ^ 7'h30, ~l);
      end else if (lone && (mem_rd_req || mem_wr_req)) begin
        chk("addr_hold", mem_addr, a);
        if (wr) chk("line_hold", mem_wr_line, l);
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL gnt_timeout: port %0d addr %0h got no gnt expected gnt", p, a);
    end
    drive(p, 0, 0, a, l);
  endtask

  // main_mem stand-in: grants after a delay, scrambles rd_line outside the grant cycle
  initial begin
    mem_gnt = 0;
    mem_rd_line = '0;
    forever begin
      @(negedge clk);
      if (rst && (mem_rd_req || mem_wr_req) && !mem_gnt) begin
        int d;
        d = mem_delay != 0 ? mem_delay : int'($urandom_range(1, 8));
        repeat (d - 1) @(negedge clk);
        if (mem_rd_req || mem_wr_req) begin
          if (mem_wr_req) mm[mem_addr] = mem_wr_line;
          else mem_rd_line = mm[mem_addr];
          mem_gnt = 1;
          @(negedge clk);
          mem_gnt = 0;
          mem_rd_line = rnd_line();
        end
      end
    end
  end

  always @(posedge clk) gnt_due <= rst && mem_gnt && (mem_rd_req || mem_wr_req);

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("gnt_pulse", {m0_gnt | m1_gnt, m0_gnt & m1_gnt}, {gnt_due, 1'b0});
        if (gnt_due) chk("req_drop", {mem_rd_req, mem_wr_req}, 2'b00);
        if (m0_gnt) begin
          gnt_log.push_back(0);
          if (q0.size() == 0) begin n_checks++; n_fail++; $display("FAIL unexpected_gnt0: got gnt expected none"); end
          else chk("rd_line0", m0_rd_line, q0.pop_front());
        end
        if (m1_gnt) begin
          gnt_log.push_back(1);
          if (q1.size() == 0) begin n_checks++; n_fail++; $display("FAIL unexpected_gnt1: got gnt expected none"); end
          else chk("rd_line1", m1_rd_line, q1.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_order [3];
    line_t l;
    clk = 0; rst = 0;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    for (int a = 0; a < 128; a++) begin ref_mem[a] = init_line(a); mm[a] = init_line(a); end
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {mem_rd_req, mem_wr_req}, 2'b00);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wr_line", mem_wr_line, 0);
    chk("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
    chk("rst_rd_line0", m0_rd_line, 0);
    chk("rst_rd_line1", m1_rd_line, 0);
    rst = 1;
    mon_en = 1;
    // contention from reset, twice in a row
    gnt_log.delete();
    fork
      do_txn(0, 1, 0, 7'h21, '0, 0);
      do_txn(1, 1, 0, 7'h41, '0, 0);
    join
    fork
      do_txn(0, 1, 0, 7'h22, '0, 0);
      do_txn(1, 1, 0, 7'h42, '0, 0);
    join
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_order = '{1, 0, 1};
`else
    exp_order = '{0, 1, 0};
`endif
    if (gnt_log.size() < 3) begin n_checks++; n_fail++; $display("FAIL rr_count: got %0d expected 3", gnt_log.size()); end
    else for (int i = 0; i < 3; i++) chk("rr_order", gnt_log[i], exp_order[i]);
    do_txn(0, 1, 0, 7'h12, '0, 1);
    l = {8{32'hA5A5_A5A5}};
    do_txn(1, 0, 1, 7'h05, l, 1);
    do_txn(0, 1, 0, 7'h05, '0, 1);
    chk("readback_a5", m0_rd_line, l);
    do_txn(1, 1, 0, 7'h10, '0, 1);
    do_txn(0, 1, 1, 7'h2A, rnd_line(), 1);
    do_txn(0, 1, 0, 7'h2A, '0, 1);
    // reset in the middle of a read: no grant must ever appear for it
    mem_delay = 8;
    @(negedge clk);
    drive(0, 1, 0, 7'h33, '0);
    @(negedge clk);
    chk("abort_req_up", mem_rd_req, 1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("abort_reqs", {mem_rd_req, mem_wr_req}, 2'b00);
    chk("abort_gnt", {m0_gnt, m1_gnt}, 2'b00);
    chk("abort_rd_line", m0_rd_line, 0);
    rst = 1;
    drive(0, 0, 0, '0, '0);
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (12) @(negedge clk);
    mem_delay = 0;
    do_txn(0, 1, 0, 7'h33, '0, 1);
    fork
      for (int i = 0; i < 20; i++) begin
        int r = $urandom_range(0, 2);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_txn(0, r != 1, r != 0, 7'($urandom_range(0, 63)), rnd_line(), 0);
      end
      for (int i = 0; i < 20; i++) begin
        int r = $urandom_range(0, 2);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_txn(1, r != 1, r != 0, 7'($urandom_range(64, 127)), rnd_line(), 0);
      end
    join
    repeat (10) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
